wb_bram_burst: RTL and testbench

//  Parametrised Wishbone B4 slave block RAM, successor to the single-beat BRAM controller.

---
 rtl/wb_bram_burst_if.sv | 29 ++
 rtl/wb_bram_burst.sv | 166 ++++++++++++++++
 tb/tb_wb_bram_burst.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 slave-side bundle for the burst-capable block RAM.
// Master drives the request fields; the slave drives the reply fields.
interface wb_bram_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADR_W-1:0]      adr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     dat_ms;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic [DATA_W-1:0]     dat_sm;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block RAM slave: registered classic cycles, linear/wrap bursts at one
// beat per clock, and an error reply for addresses beyond the memory depth.
module wb_bram_burst #(
    parameter int DATA_W    = 32,
    parameter int MEM_ADR_W = 11,
    parameter int ADR_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    wb_bram_burst_if.slave     bus,
    output logic [1:0]         state_dbg
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int TOP   = MEM_ADR_W + LB;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        BURST = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t                 state;
    logic                   ack_r;
    logic                   err_r;
    logic [DATA_W-1:0]      dat_r;
    logic [MEM_ADR_W-1:0]   cnt;
    logic [MEM_ADR_W-1:0]   cnt_nxt;
    logic [MEM_ADR_W-1:0]   word_idx;
    logic [MEM_ADR_W-1:0]   rd_idx;
    logic [MEM_ADR_W-1:0]   wr_idx;
    logic                   req;
    logic                   oor;
    logic                   wr_en;

    logic [DATA_W-1:0] mem [2**MEM_ADR_W];

    // Handshake: a beat is requested while cyc & stb are high and completes on the
    // clock edge where ack (or err) is sampled high; the master holds every request
    // field stable until then. ack and err are never high together.

    assign req      = bus.cyc & bus.stb;
    assign word_idx = bus.adr[TOP-1:LB];

    generate
        if (ADR_W > TOP) begin : g_range
            assign oor = |bus.adr[ADR_W-1:TOP];
        end else begin : g_no_range
            assign oor = 1'b0;
        end
        if (LB > 0) begin : g_lane_bits
            logic unused_lane_bits;
            assign unused_lane_bits = &{1'b0, bus.adr[LB-1:0]};
        end
    endgenerate

    function automatic logic [MEM_ADR_W-1:0] burst_next(
        input logic [MEM_ADR_W-1:0] cur,
        input logic [1:0]           bte
    );
        logic [MEM_ADR_W-1:0] mask;
        case (bte)
            2'b01:   mask = MEM_ADR_W'(3);
            2'b10:   mask = MEM_ADR_W'(7);
            2'b11:   mask = MEM_ADR_W'(15);
            default: mask = '1;
        endcase
        // Wrap bursts advance only the low bits; linear uses a full mask.
        return (cur & ~mask) | ((cur + MEM_ADR_W'(1)) & mask);
    endfunction

    assign cnt_nxt = burst_next(cnt, bus.bte);

    always_comb begin
        rd_idx = word_idx;
        wr_idx = word_idx;
        wr_en  = 1'b0;
        case (state)
            IDLE: begin
                wr_en = req & ~oor & bus.we;
            end
            BURST: begin
                rd_idx = req ? cnt_nxt : cnt;
                wr_idx = cnt;
                wr_en  = req & bus.we;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // No reset on the array: contents survive rst, but a beat pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.sel[i]) begin
                    mem[wr_idx][8*i +: 8] <= bus.dat_ms[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= '0;
            cnt   <= '0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (oor) begin
                            state <= ERR;
                            err_r <= 1'b1;
                        end else begin
                            dat_r <= mem[rd_idx];
                            cnt   <= word_idx;
                            if (bus.cti == CTI_INCR) begin
                                state <= BURST;
                            end else begin
                                state <= ACK;
                                ack_r <= 1'b1;
                            end
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                BURST: begin
                    // Prefetch the next word on accept so read data is ready every beat.
                    dat_r <= mem[rd_idx];
                    if (!bus.cyc) begin
                        state <= IDLE;
                    end else if (bus.stb) begin
                        cnt <= cnt_nxt;
                        if (bus.cti == CTI_EOB) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack    = ack_r | ((state == BURST) & req);
    assign bus.err    = err_r;
    assign bus.rty    = 1'b0;
    assign bus.dat_sm = dat_r;
    assign state_dbg  = state;
endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: a classic-cycle vector table followed by
// hand-written burst, stall, wrap, boundary and mid-burst reset sequences.
module tb_wb_bram_burst;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_fail;

    wb_bram_burst_if #(.DATA_W(32), .ADR_W(32)) bus ();

    wb_bram_burst #(.DATA_W(32), .MEM_ADR_W(11), .ADR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] bw[16];
    logic [31:0] bx[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives at posedge+1; samples one step later so the combinational ack has settled.
    task automatic do_classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, output logic got_ack, output logic got_err,
                              output logic [31:0] rd, output int lat);
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.sel = s;
        bus.dat_ms = d; bus.cti = 3'b000; bus.bte = 2'b00;
        #1;
        lat = 0;
        while (!bus.ack && !bus.err && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        got_ack = bus.ack;
        got_err = bus.err;
        rd      = bus.dat_sm;
        bus.cyc = 1'b0; bus.stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic classic_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic        ga, ge;
        logic [31:0] rd;
        int          lat;
        do_classic(1'b0, a, 4'hF, 32'h0, ga, ge, rd, lat);
        check({name, "_ack"}, {31'b0, ga}, 32'd1);
        check({name, "_dat"}, rd, exp);
    endtask

    task automatic do_burst(input logic w, input logic [31:0] a, input logic [1:0] b,
                            input int n, input int stall_at, input string tag);
        int k;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.sel = 4'hF; bus.bte = b;
        for (int i = 0; i < n; i++) begin
            bus.cti    = (i == n - 1) ? 3'b111 : 3'b010;
            bus.dat_ms = bw[i];
            if (i == stall_at) begin
                bus.stb = 1'b0;
                repeat (2) begin
                    #1;
                    check({tag, "_stall_ack"}, {31'b0, bus.ack}, 32'd0);
                    @(posedge clk); #1;
                end
                bus.stb = 1'b1;
            end
            #1;
            k = 0;
            while (!bus.ack && k < 8) begin
                @(posedge clk); #1;
                k++;
            end
            check({tag, "_ack"}, {31'b0, bus.ack}, 32'd1);
            check({tag, "_lat"}, k, (i == 0) ? 32'd1 : 32'd0);
            check({tag, "_err"}, {31'b0, bus.err}, 32'd0);
            if (!w) check({tag, "_dat"}, bus.dat_sm, bx[i]);
            @(posedge clk); #1;
        end
        check({tag, "_end_state"}, {30'b0, state_dbg}, 32'd0);
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.cti = 3'b000;
        #1;
        check({tag, "_end_ack"}, {31'b0, bus.ack}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic        ga, ge;
        logic [31:0] rd;
        int          lat;
        int          k;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000_AA00, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_AAEF};
        vecs[4]  = '{1'b0, 32'h0000_0013, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_AAEF};
        vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_1FFC, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_1FFC, 4'h9, 32'h11AA_AA22, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_1FFC, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1134_5622};
        vecs[9]  = '{1'b0, 32'h0000_2000, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_2000, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h8000_0010, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[13] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_AAEF};
        vecs[14] = '{1'b1, 32'h0000_0208, 4'hF, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 32'h0};

        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.sel = '0;
        bus.dat_ms = '0; bus.cti = 3'b000; bus.bte = 2'b00;

        // Clock/reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_ack",    {31'b0, bus.ack}, 32'd0);
        check("rst_err",    {31'b0, bus.err}, 32'd0);
        check("rst_rty",    {31'b0, bus.rty}, 32'd0);
        check("rst_dat",    bus.dat_sm, 32'h0);
        check("rst_state",  {30'b0, state_dbg}, 32'd0);
        @(posedge clk); #1;

        // Classic vector table
        for (int i = 0; i < 15; i++) begin
            do_classic(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, ga, ge, rd, lat);
            check($sformatf("vec%0d_ack", i), {31'b0, ga}, {31'b0, vecs[i].exp_ack});
            check($sformatf("vec%0d_err", i), {31'b0, ge}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i), lat, 32'd1);
            if (vecs[i].chk_dat) check($sformatf("vec%0d_dat", i), rd, vecs[i].exp_dat);
            #1;
            check($sformatf("vec%0d_ack_drop", i), {31'b0, bus.ack}, 32'd0);
            check($sformatf("vec%0d_err_drop", i), {31'b0, bus.err}, 32'd0);
        end
        classic_read_chk("oor_alias_last", 32'h0000_1FFC, 32'h1134_5622);

        // Linear write then read burst
        for (int i = 0; i < 16; i++) bw[i] = 32'(i + 1);
        do_burst(1'b1, 32'h0000_0100, 2'b00, 4, -1, "lin_wr");
        bx[0] = 32'd1; bx[1] = 32'd2; bx[2] = 32'd3; bx[3] = 32'd4;
        do_burst(1'b0, 32'h0000_0100, 2'b00, 4, -1, "lin_rd");

        // Wrap4 from word 2 of the block
        bx[0] = 32'd3; bx[1] = 32'd4; bx[2] = 32'd1; bx[3] = 32'd2;
        do_burst(1'b0, 32'h0000_0108, 2'b01, 4, -1, "wrap4_rd");

        // Two-cycle master wait state before beat 2
        bx[0] = 32'd1; bx[1] = 32'd2; bx[2] = 32'd3; bx[3] = 32'd4;
        do_burst(1'b0, 32'h0000_0100, 2'b00, 4, 2, "stall_rd");

        // Wrap16 write from the last word of the 16-word block
        for (int i = 0; i < 4; i++) bw[i] = 32'h10 + 32'(i);
        do_burst(1'b1, 32'h0000_013C, 2'b11, 4, -1, "wrap16_wr");
        classic_read_chk("wrap16_w13c", 32'h0000_013C, 32'h10);
        classic_read_chk("wrap16_w100", 32'h0000_0100, 32'h11);
        classic_read_chk("wrap16_w104", 32'h0000_0104, 32'h12);
        classic_read_chk("wrap16_w108", 32'h0000_0108, 32'h13);
        classic_read_chk("wrap16_w10c", 32'h0000_010C, 32'h4);

        // Linear burst rolls over from the top word to word 0
        bx[0] = 32'h1134_5622; bx[1] = 32'hCAFE_F00D;
        do_burst(1'b0, 32'h0000_1FFC, 2'b00, 2, -1, "lin_roll");

        // Reset in the middle of a write burst: beat 2 must be dropped
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h0000_0200;
        bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b00; bus.dat_ms = 32'hA0;
        #1;
        k = 0;
        while (!bus.ack && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        check("rstb_beat0_ack", {31'b0, bus.ack}, 32'd1);
        @(posedge clk); #1;
        bus.dat_ms = 32'hA1;
        #1;
        check("rstb_beat1_ack", {31'b0, bus.ack}, 32'd1);
        @(posedge clk); #1;
        bus.dat_ms = 32'h0000_0BAD;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.cti = 3'b000;
        #1;
        check("rstb_ack",   {31'b0, bus.ack}, 32'd0);
        check("rstb_err",   {31'b0, bus.err}, 32'd0);
        check("rstb_dat",   bus.dat_sm, 32'h0);
        check("rstb_state", {30'b0, state_dbg}, 32'd0);
        @(posedge clk); #1;
        classic_read_chk("rstb_w200", 32'h0000_0200, 32'hA0);
        classic_read_chk("rstb_w204", 32'h0000_0204, 32'hA1);
        classic_read_chk("rstb_w208", 32'h0000_0208, 32'h5555_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
